// File: rtl/seg_pkg.sv
// Shared constants for the BCD counter / seven-segment display slice.
// Segment patterns are active-low: bit7 = decimal point (kept off),
// bits [6:0] = g..a.
package seg_pkg;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam logic [3:0] BCD_MAX   = 4'd9;

endpackage

// File: rtl/seg_bcd_decoder.sv
// Combinational BCD digit to active-low seven-segment pattern.
// Ports:
//   digit  in  4  BCD digit (values above 9 show as blank)
//   seg    out 8  active-low segments, bit7 = decimal point (always off)
module seg_bcd_decoder
   import seg_pkg::*;
(
   input  logic [3:0] digit,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_bcd_counter_display.sv
// Multi-digit BCD up/down counter driving a time-multiplexed
// seven-segment display.
// Ports:
//   clk        in  1              clock
//   rst        in  1              synchronous, active-low reset
//   en         in  1              count enable, sampled on tick
//   up_dn      in  1              1 = count up, 0 = count down
//   sat_mode   in  1              1 = saturate at limits, 0 = wrap
//   load       in  1              synchronous load strobe
//   load_val   in  4*NUM_DIGITS   BCD load value, digit 0 in [3:0]
//   blank_lz   in  1              1 = blank leading zeros
//   value      out 4*NUM_DIGITS   current BCD count
//   tc         out 1              one-cycle pulse on wrap/saturate hit
//   seg        out 8              active-low segments (bit7 = dp, off)
//   digit_sel  out NUM_DIGITS     active-low one-hot position select
module seg_bcd_counter_display
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int TICK_DIV   = 50000000,
   parameter int SCAN_DIV   = 131072
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    up_dn,
   input  logic                    sat_mode,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_val,
   input  logic                    blank_lz,
   output logic [4*NUM_DIGITS-1:0] value,
   output logic                    tc,
   output logic [7:0]              seg,
   output logic [NUM_DIGITS-1:0]   digit_sel
);

   localparam int VW = 4 * NUM_DIGITS;
   localparam int TW = $clog2(TICK_DIV);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   logic [TW-1:0] tick_cnt;
   logic [SW-1:0] scan_cnt;
   logic [IW-1:0] idx;
   logic          tick;
   logic          scan_wrap;

   logic [VW-1:0] load_clamped;
   logic [VW-1:0] val_inc;
   logic [VW-1:0] val_dec;
   logic          all_nines;
   logic          all_zero;
   logic [3:0]    d_up;
   logic [3:0]    d_dn;

   logic [3:0]    cur_digit;
   logic [7:0]    dec_seg;
   logic          upper_zero;
   logic          blank;

   assign tick      = (tick_cnt == TICK_LAST);
   assign scan_wrap = (scan_cnt == SCAN_LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   always_comb begin
      load_clamped = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         load_clamped[4*i +: 4] = (load_val[4*i +: 4] > BCD_MAX) ? BCD_MAX
                                                                  : load_val[4*i +: 4];
      end
   end

   // Ripple carry/borrow across digits. The carry-out of the increment
   // is exactly the all-9s condition and the borrow-out of the
   // decrement is exactly the all-zero condition, and the wrapped
   // results (all zeros / all nines) fall out of the ripple for free.
   always_comb begin
      val_inc   = value;
      val_dec   = value;
      all_nines = 1'b1;
      all_zero  = 1'b1;
      d_up      = '0;
      d_dn      = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         d_up = value[4*i +: 4];
         if (all_nines) begin
            if (d_up >= BCD_MAX) begin
               val_inc[4*i +: 4] = 4'd0;
            end else begin
               val_inc[4*i +: 4] = d_up + 4'd1;
               all_nines         = 1'b0;
            end
         end
         d_dn = value[4*i +: 4];
         if (all_zero) begin
            if (d_dn == 4'd0) begin
               val_dec[4*i +: 4] = BCD_MAX;
            end else begin
               val_dec[4*i +: 4] = d_dn - 4'd1;
               all_zero          = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         value <= '0;
         tc    <= 1'b0;
      end else if (load) begin
         value <= load_clamped;
         tc    <= 1'b0;
      end else if (tick && en) begin
         if (up_dn) begin
            tc <= all_nines;
            if (!(all_nines && sat_mode)) begin
               value <= val_inc;
            end
         end else begin
            tc <= all_zero;
            if (!(all_zero && sat_mode)) begin
               value <= val_dec;
            end
         end
      end else begin
         tc <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else if (scan_wrap) begin
         scan_cnt <= '0;
         idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   assign cur_digit = value[{idx, 2'b00} +: 4];

   // Walk from the most significant digit down; upper_zero at position i
   // means every digit at positions >= i is zero.
   always_comb begin
      upper_zero = 1'b1;
      blank      = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (value[4*i +: 4] != 4'd0) begin
            upper_zero = 1'b0;
         end
         if ((i != 0) && (IW'(i) == idx) && upper_zero) begin
            blank = blank_lz;
         end
      end
   end

   seg_bcd_decoder u_dec (
      .digit (cur_digit),
      .seg   (dec_seg)
   );

   // Both display registers are loaded from the same idx so segment
   // data and position select always move together.
   always_ff @(posedge clk) begin
      if (!rst) begin
         seg       <= SEG_0;
         digit_sel <= ~NUM_DIGITS'(1);
      end else begin
         seg       <= blank ? SEG_BLANK : dec_seg;
         digit_sel <= ~(NUM_DIGITS'(1) << idx);
      end
   end

endmodule

// File: tb/tb_seg_bcd_counter_display.sv
module tb_seg_bcd_counter_display;

   localparam int ND  = 4;
   localparam int TD  = 4;
   localparam int SD  = 2;
   localparam int MOD = 10000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        up_dn = 1'b1;
   logic        sat_mode = 1'b0;
   logic        load = 1'b0;
   logic [15:0] load_val = 16'h0;
   logic        blank_lz = 1'b0;
   logic [15:0] value;
   logic        tc;
   logic [7:0]  seg;
   logic [3:0]  digit_sel;

   seg_bcd_counter_display #(
      .NUM_DIGITS (ND),
      .TICK_DIV   (TD),
      .SCAN_DIV   (SD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .up_dn     (up_dn),
      .sat_mode  (sat_mode),
      .load      (load),
      .load_val  (load_val),
      .blank_lz  (blank_lz),
      .value     (value),
      .tc        (tc),
      .seg       (seg),
      .digit_sel (digit_sel)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit auto_chk = 1'b0;

   // reference model: count kept as a plain integer 0..MOD-1
   int         m_val = 0;
   int         m_tick = 0;
   int         m_scan = 0;
   int         m_idx = 0;
   logic       m_tc = 1'b0;
   logic [7:0] m_seg = 8'hC0;
   logic [3:0] m_dsel = 4'b1110;

   int         pow10 [ND] = '{1, 10, 100, 1000};
   logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   typedef struct {
      logic [15:0] lv;
      bit          up;
      bit          sat;
      logic [15:0] exp_val;
      int          exp_tcn;
   } vec_t;

   vec_t vecs [10];

   function automatic int load_int(input logic [15:0] lv);
      int r = 0;
      int n;
      for (int i = 0; i < ND; i++) begin
         n = int'(lv[4*i +: 4]);
         if (n > 9) n = 9;
         r += n * pow10[i];
      end
      return r;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r = '0;
      for (int i = 0; i < ND; i++) begin
         r[4*i +: 4] = 4'((v / pow10[i]) % 10);
      end
      return r;
   endfunction

   task automatic model_step();
      bit tk;
      bit blank;
      int dgt;
      if (!rst) begin
         m_val  = 0;
         m_tick = 0;
         m_scan = 0;
         m_idx  = 0;
         m_tc   = 1'b0;
         m_seg  = 8'hC0;
         m_dsel = 4'b1110;
      end else begin
         m_dsel = ~(4'b0001 << m_idx);
         dgt    = (m_val / pow10[m_idx]) % 10;
         blank  = blank_lz && (m_idx > 0) && ((m_val / pow10[m_idx]) == 0);
         m_seg  = blank ? 8'hFF : seg_tbl[dgt];
         tk     = (m_tick == TD - 1);
         m_tick = tk ? 0 : m_tick + 1;
         if (load) begin
            m_val = load_int(load_val);
            m_tc  = 1'b0;
         end else if (tk && en) begin
            if (up_dn) begin
               m_tc = (m_val == MOD - 1);
               if (!(m_tc && sat_mode)) m_val = (m_val + 1) % MOD;
            end else begin
               m_tc = (m_val == 0);
               if (!(m_tc && sat_mode)) m_val = (m_val + MOD - 1) % MOD;
            end
         end else begin
            m_tc = 1'b0;
         end
         if (m_scan == SD - 1) begin
            m_scan = 0;
            m_idx  = (m_idx == ND - 1) ? 0 : m_idx + 1;
         end else begin
            m_scan++;
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clk1();
      @(posedge clk);
      model_step();
      #2;
      if (auto_chk) begin
         chk("value", 32'(value), 32'(to_bcd(m_val)));
         chk("tc", 32'(tc), 32'(m_tc));
         chk("seg", 32'(seg), 32'(m_seg));
         chk("digit_sel", 32'(digit_sel), 32'(m_dsel));
      end
   endtask

   initial begin
      int         tcn;
      logic [3:0] seen;
      logic [3:0] exp_seq [9];

      vecs[0] = '{16'h9999, 1'b1, 1'b0, 16'h0000, 1};
      vecs[1] = '{16'h9999, 1'b1, 1'b1, 16'h9999, 1};
      vecs[2] = '{16'h0000, 1'b0, 1'b0, 16'h9999, 1};
      vecs[3] = '{16'h0000, 1'b0, 1'b1, 16'h0000, 1};
      vecs[4] = '{16'h1000, 1'b0, 1'b0, 16'h0999, 0};
      vecs[5] = '{16'h0199, 1'b1, 1'b0, 16'h0200, 0};
      vecs[6] = '{16'h0909, 1'b1, 1'b1, 16'h0910, 0};
      vecs[7] = '{16'h2000, 1'b0, 1'b1, 16'h1999, 0};
      vecs[8] = '{16'hFA32, 1'b1, 1'b0, 16'h9933, 0};
      vecs[9] = '{16'h0005, 1'b0, 1'b0, 16'h0004, 0};

      exp_seq = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011,
                  4'b1011, 4'b0111, 4'b0111, 4'b1110};

      // reset baseline
      rst = 1'b0;
      clk1();
      auto_chk = 1'b1;
      clk1();
      clk1();
      chk("rst_value", 32'(value), 32'h0000);
      chk("rst_seg", 32'(seg), 32'hC0);
      chk("rst_dsel", 32'(digit_sel), 32'b1110);
      chk("rst_tc", 32'(tc), 32'h0);

      // blanking with count at zero
      rst = 1'b1;
      blank_lz = 1'b1;
      clk1();
      for (int k = 0; k < 8; k++) begin
         clk1();
         if (digit_sel == 4'b1110) chk("blank_pos0", 32'(seg), 32'hC0);
         else                      chk("blank_posN", 32'(seg), 32'hFF);
      end

      // count up: 40 consecutive cycles contain exactly 10 ticks
      en = 1'b1;
      up_dn = 1'b1;
      repeat (40) clk1();
      chk("count_up_10", 32'(value), 32'h0010);
      en = 1'b0;
      seen = '0;
      for (int k = 0; k < 8; k++) begin
         clk1();
         seen = seen | ~digit_sel;
         case (digit_sel)
            4'b1110: chk("pos0_digit", 32'(seg), 32'hC0);
            4'b1101: chk("pos1_digit", 32'(seg), 32'hF9);
            4'b1011: chk("pos2_blank", 32'(seg), 32'hFF);
            4'b0111: chk("pos3_blank", 32'(seg), 32'hFF);
            default: chk("dsel_onehot", 32'(digit_sel), 32'(m_dsel));
         endcase
      end
      chk("all_pos_seen", 32'(seen), 32'hF);

      // table vectors: load then exactly one tick in the next 4 cycles
      for (int v = 0; v < 10; v++) begin
         blank_lz = v[0];
         sat_mode = vecs[v].sat;
         up_dn    = vecs[v].up;
         load_val = vecs[v].lv;
         load     = 1'b1;
         en       = 1'b1;
         clk1();
         load = 1'b0;
         tcn  = 0;
         for (int k = 0; k < 4; k++) begin
            clk1();
            if (tc === 1'b1) tcn++;
         end
         chk($sformatf("vec%0d_value", v), 32'(value), 32'(vecs[v].exp_val));
         chk($sformatf("vec%0d_tc_pulses", v), 32'(tcn), 32'(vecs[v].exp_tcn));
      end

      // saturate up: tc on every tick, value held
      sat_mode = 1'b1;
      up_dn    = 1'b1;
      load_val = 16'h9999;
      load     = 1'b1;
      clk1();
      load = 1'b0;
      tcn  = 0;
      for (int k = 0; k < 12; k++) begin
         clk1();
         if (tc === 1'b1) tcn++;
      end
      chk("sat_value", 32'(value), 32'h9999);
      chk("sat_tc_pulses", 32'(tcn), 32'd3);

      // load coincident with tick: clamp, no step, tc low
      sat_mode = 1'b0;
      for (int k = 0; k < 10 && m_tick != TD - 1; k++) clk1();
      chk("align_tick_timeout", 32'(m_tick), 32'(TD - 1));
      load_val = 16'hFA32;
      load     = 1'b1;
      clk1();
      load = 1'b0;
      chk("load_prio_value", 32'(value), 32'h9932);
      chk("load_prio_tc", 32'(tc), 32'h0);
      en = 1'b0;

      // reset mid-scan at the last position
      for (int k = 0; k < 20 && m_idx != ND - 1; k++) clk1();
      chk("align_idx_timeout", 32'(m_idx), 32'(ND - 1));
      rst = 1'b0;
      clk1();
      chk("midscan_dsel", 32'(digit_sel), 32'b1110);
      chk("midscan_seg", 32'(seg), 32'hC0);
      chk("midscan_value", 32'(value), 32'h0000);
      rst = 1'b1;
      for (int k = 0; k < 9; k++) begin
         clk1();
         chk($sformatf("scan_seq%0d", k), 32'(digit_sel), 32'(exp_seq[k]));
      end

      // randomized run against the model
      for (int k = 0; k < 3000; k++) begin
         en       = ($urandom_range(0, 3) != 0);
         up_dn    = 1'($urandom_range(0, 1));
         sat_mode = 1'($urandom_range(0, 1));
         load     = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 1) == 0) begin
            case ($urandom_range(0, 3))
               0: load_val = 16'h9999;
               1: load_val = 16'h0000;
               2: load_val = 16'h9998;
               default: load_val = 16'h0001;
            endcase
         end else begin
            load_val = 16'($urandom);
         end
         if ($urandom_range(0, 7) == 0) blank_lz = ~blank_lz;
         rst = ($urandom_range(0, 199) != 0);
         clk1();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg_bcd_counter_display.md
Name: seg_bcd_counter_display

Overview:
- Parametrised multi-digit BCD up/down counter with a time-multiplexed seven-segment display driver.
- Sits between the board clock/reset and the segment/digit-select pins.
- Adds the following over the single-digit countdown display:
  - configurable digit count and tick/scan rates
  - load
  - up/down, wrap or saturate
  - leading-zero blanking
  - terminal-count pulse
- Segment data and digit select are driven from the same registered digit index, so the display never shows a digit's value on the wrong position.

Parameters:
- NUM_DIGITS, 6, number of BCD digits and display positions (1..8).
- TICK_DIV, 50000000, clk cycles per count step (>=2); 50000000 gives 1 s at 50 MHz.
- SCAN_DIV, 131072, clk cycles per display position (>=2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- en  in  1  count enable, sampled on tick.
- up_dn  in  1  1 = count up, 0 = count down.
- sat_mode  in  1  1 = saturate at the limits, 0 = wrap.
- load  in  1  synchronous load strobe.
- load_val  in  4*NUM_DIGITS  BCD load value; digit 0 occupies bits [3:0].
- blank_lz  in  1  1 = blank leading zeros.
- value  out  4*NUM_DIGITS  current BCD count.
- tc  out  1  one-cycle pulse on wrap or saturate hit.
- seg  out  8  active-low segments; bit7 is the decimal point (always 1); bits [6:0] are g..a.
- digit_sel  out  NUM_DIGITS  active-low one-hot position select.

Behaviour:
- Reset (rst=0 at posedge): value=0, tick_cnt=0, scan_cnt=0, idx=0, tc=0, digit_sel=~1 (only position 0 low), seg=8'hC0. Reset mid-operation aborts any count or scan immediately.
- tick_cnt counts 0..TICK_DIV-1 and wraps. tick is asserted in the cycle tick_cnt==TICK_DIV-1. tick_cnt runs regardless of en.
- Priority on each posedge: reset > load > (tick & en) step > hold.
- Load:
  - value <= load_val, visible on the next cycle.
  - Any load nibble >9 is clamped to 9.
  - load does not reset tick_cnt.
  - tc=0 on a load cycle.
- Step up:
  - BCD increment with ripple carry across digits.
  - At all-9s: sat_mode=0 gives value <= 0; sat_mode=1 holds the value. tc=1 for that cycle in both cases.
- Step down:
  - BCD decrement with borrow.
  - At 0: sat_mode=0 gives value <= all-9s; sat_mode=1 holds 0. tc=1 in both cases.
- tc is registered and high for exactly one cycle per qualifying tick. It stays high again on every subsequent tick while saturated and enabled.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1.
  - On wrap, idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1.
- Display registers update every cycle:
  - digit_sel <= ~(1<<idx).
  - seg <= decode(value digit idx).
  - Latency is 1 cycle from an idx or value change. seg and digit_sel always change in the same cycle.
- Decode table (active-low, hex):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
  - any other input = FF
- Blanking: if blank_lz=1, idx>0, and every digit at positions >=idx is 0, then seg <= FF. Digit 0 is never blanked.
- en=0 freezes value only. Scan and tick continue.

Decomposition:
- Shared package seg_pkg holds:
  - the ten segment constants SEG_0..SEG_9
  - SEG_BLANK = 8'hFF
  - BCD_MAX = 4'd9
- One combinational sub-module, seg_bcd_decoder, maps a 4-bit BCD digit to the 8-bit pattern.
- The counter, tick divider, scan divider and blanking logic stay in the top module.

Test Plan:
1. Reset and blanking baseline, NUM_DIGITS=4, TICK_DIV=4, SCAN_DIV=2: hold rst=0 for 3 cycles -> value=0000, seg=C0, digit_sel=1110, tc=0. Release with blank_lz=1 -> positions 1..3 show FF and position 0 shows C0.
2. Count up: en=1, up_dn=1 for 40 cycles -> value=0010 after 10 ticks. Position 1 shows F9 and position 0 shows C0, each in the same cycle as its digit_sel.
3. Up wrap vs. saturate: load 9999 with sat_mode=0, then one tick -> value=0000 and one tc pulse. Repeat with sat_mode=1 -> value stays 9999 and tc pulses on every tick.
4. Down wrap and borrow: load 1000, up_dn=0 -> next tick gives 0999. Load 0000 with sat_mode=0, then tick -> 9999 with tc=1.
5. Load clamp and priority: load_val=4'hF,4'hA,3,2 asserted in the same cycle as tick&en -> value=9932. No step is applied and tc=0.
6. Mid-scan reset: assert rst=0 while idx=3 -> next cycle idx=0, digit_sel=1110, seg=C0. Scanning then resumes 0,1,2,3,0 every SCAN_DIV cycles.
